// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract with carry/overflow/zero flags, carry chain cut into STAGES slices.
// Latency STAGES cycles, one op per cycle; a stalled output freezes the whole pipe and drops in_ready.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int S = WIDTH / STAGES;

    logic             adv;
    logic [WIDTH-1:0] b_x;
    logic             ovf_q;
    logic             zero_q;

    assign b_x = b ^ {WIDTH{sub}};

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // Operands shrink by one slice per stage: only unconsumed upper slices travel on.
        localparam int RW = WIDTH - S * k;

        logic [RW-1:0]    a_in;
        logic [RW-1:0]    b_in;
        logic             cin;
        logic             vld_in;
        logic [WIDTH-1:0] res_in;
        logic [WIDTH-1:0] res_n;
        logic [WIDTH-1:0] res_q;
        logic [S:0]       sum;
        logic             vld_q;
        logic             carry_q;

        if (k == 0) begin : g_src
            assign a_in   = a;
            assign b_in   = b_x;
            assign cin    = sub;
            assign res_in = '0;
            assign vld_in = in_valid;
        end else begin : g_src
            assign a_in   = g_st[k-1].g_ops.opa_q;
            assign b_in   = g_st[k-1].g_ops.opb_q;
            assign cin    = g_st[k-1].carry_q;
            assign res_in = g_st[k-1].res_q;
            assign vld_in = g_st[k-1].vld_q;
        end

        assign sum   = {1'b0, a_in[S-1:0]} + {1'b0, b_in[S-1:0]} + {{S{1'b0}}, cin};
        assign res_n = res_in | (WIDTH'(sum[S-1:0]) << (S * k));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q   <= 1'b0;
                res_q   <= '0;
                carry_q <= 1'b0;
            end else if (adv) begin
                vld_q   <= vld_in;
                res_q   <= res_n;
                carry_q <= sum[S];
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [RW-S-1:0] opa_q;
            logic [RW-S-1:0] opb_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (adv) begin
                    opa_q <= a_in[RW-1:S];
                    opb_q <= b_in[RW-1:S];
                end
            end
        end
    end

    // Carry into the MSB is recovered from the last slice's top sum bit and its operand bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            ovf_q  <= g_st[STAGES-1].a_in[S-1] ^ g_st[STAGES-1].b_in[S-1]
                    ^ g_st[STAGES-1].sum[S-1] ^ g_st[STAGES-1].sum[S];
            zero_q <= (g_st[STAGES-1].res_n == '0);
        end
    end

    assign out_valid = g_st[STAGES-1].vld_q;
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign y         = g_st[STAGES-1].res_q;
    assign cout      = g_st[STAGES-1].carry_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: 32-bit/4-stage instance plus an 8-bit/1-stage instance.
module tb_pipe_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] a, b, y;

    logic        in_valid8, in_ready8, sub8, out_valid8, out_ready8, cout8, ovf8, zero8;
    logic [7:0]  a8, b8, y8;

    typedef struct {
        logic [31:0] y;
        logic        c;
        logic        o;
        logic        z;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   seen  = 0;

    pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipe_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
        .y(y8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] aa, input logic [31:0] bb, input logic s);
        exp_t        r;
        logic [32:0] f;
        logic [31:0] bx;
        bx  = s ? ~bb : bb;
        f   = {1'b0, aa} + {1'b0, bx} + 33'(s);
        r.y = f[31:0];
        r.c = f[32];
        r.o = s ? ((aa[31] != bb[31]) && (r.y[31] != aa[31]))
                : ((aa[31] == bb[31]) && (r.y[31] != aa[31]));
        r.z = (r.y == 32'h0);
        r.acc = 0;
        r.lat = 0;
        return r;
    endfunction

    task automatic send(input logic [31:0] aa, input logic [31:0] bb, input logic s, input bit lat);
        exp_t e;
        bit   ok;
        ok = 0;
        a = aa; b = bb; sub = s; in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e     = model(aa, bb, s);
                e.acc = cyc + 1;
                e.lat = lat;
                sb.push_back(e);
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        check("drain_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    // Output side: every presented result must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                if (!seen) begin
                    seen = 1;
                    if (sb[0].lat) check("latency", 64'(cyc - sb[0].acc), 3);
                end
                check("y", y, sb[0].y);
                check("flags_c_o_z", {cout, ovf, zero}, {sb[0].c, sb[0].o, sb[0].z});
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 0;
                end else begin
                    check("in_ready_stall", in_ready, 0);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; sub8 = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_flags", {cout, ovf, zero}, 3'b000);
        #12 reset = 1'b0;
        @(posedge clk); #1;

        // Carry rippling through every slice, then the two subtract cases.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1);
        drain();
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1);
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1);
        drain();

        // Single-stage 8-bit instance.
        a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0; in_valid8 = 1'b1;
        #1 check("w8_in_ready", in_ready8, 1);
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b1;
        check("w8_vld", out_valid8, 1);
        check("w8_y_add", y8, 8'h80);
        check("w8_flags_add", {cout8, ovf8, zero8}, 3'b010);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("w8_y_sub", y8, 8'hFE);
        check("w8_flags_sub", {cout8, ovf8, zero8}, 3'b100);
        @(posedge clk); #1;
        check("w8_vld_drop", out_valid8, 0);

        // Back-to-back stream.
        for (int i = 0; i < 8; i++) send(32'(i), 32'h100, 1'b0, 1);
        drain();

        // Stream with a 3-cycle output stall.
        fork
            for (int i = 0; i < 8; i++) send(32'(i + 16), 32'h200, 1'b0, 0);
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk); #1;
                    if (out_valid) break;
                end
                check("stall_setup_vld", out_valid, 1);
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Random operands under random backpressure.
        fork
            for (int i = 0; i < 30; i++) begin
                case (i % 5)
                    0: send(32'h0, 32'h0, 1'b1, 0);
                    1: send(32'h7FFF_FFFF, 32'h1, 1'b0, 0);
                    default: send($urandom, $urandom, 1'($urandom_range(0, 1)), 0);
                endcase
            end
            begin
                repeat (80) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Flush with operations in flight.
        for (int i = 0; i < 4; i++) send(32'(i + 32'h40), 32'h1, 1'b0, 1);
        check("pre_reset_vld", out_valid, 1);
        #2 reset = 1'b1;
        sb.delete();
        seen = 0;
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_y", y, 0);
        check("flush_in_ready", in_ready, 1);
        #10 reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        send(32'h1234_0000, 32'h0000_5678, 1'b0, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
